// File: rtl/spi_slave_frontend_if.sv
// Pin-side SPI signals plus the register-map bus driven by the SPI slave front end.
interface spi_slave_frontend_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sck;
  logic                  cs_n;
  logic                  sdi;
  logic                  sdo;
  logic                  sdo_oe;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  frame_abort;

  modport slave (
    input  sck, cs_n, sdi, reg_rdata,
    output sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_abort
  );

  modport master (
    output sck, cs_n, sdi, reg_rdata,
    input  sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_abort
  );
endinterface

// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave: synchronises pins into clk, decodes {rw, addr, data} frames
// into one-cycle register strobes and shifts read data out on SDO.
module spi_slave_frontend #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_slave_frontend_if.slave bus
);
  localparam int unsigned FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned RD_BITS = 1 + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q, vld_q;
  logic                   sck_hist_q, cs_hist_q, armed_q;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_rise, sck_fall, cs_fall;

  logic [FRAME_W-2:0]    rx_q, rx_d;
  logic [FRAME_W-1:0]    rx_shift;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  rd_q, rd_d, load_q, load_d;
  logic                  sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d, re_q, re_d, abort_q, abort_d;

  // Pin synchronisers; vld_q marks when the last stage holds a real post-reset sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= '1;
      vld_q      <= '0;
      sck_hist_q <= 1'b0;
      cs_hist_q  <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sck_hist_q <= sck_s;
      cs_hist_q  <= cs_s;
      armed_q    <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_q;
  assign sck_fall = ~sck_s & sck_hist_q;
  // A CS_N already low out of reset only counts once it has been seen high
  assign cs_fall  = armed_q & cs_hist_q & ~cs_s;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_s) state_d = IDLE;
        else if (sck_rise && (cnt_inc == CNT_W'(FRAME_W))) state_d = DONE;
      end
      DONE:  if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rx_shift = {rx_q, sdi_s};
  assign cnt_inc  = bitcnt_q + CNT_W'(1);

  always_comb begin
    rx_d     = rx_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    rd_d     = rd_q;
    load_d   = re_q;
    sdo_d    = sdo_q;
    sdo_oe_d = (state_d == SHIFT) || (state_d == DONE);
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        if (cs_fall) begin
          rx_d     = '0;
          bitcnt_d = '0;
          tx_d     = '0;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          abort_d = 1'b1;
        end else if (sck_rise) begin
          rx_d     = rx_shift[FRAME_W-2:0];
          bitcnt_d = cnt_inc;
          if ((cnt_inc == CNT_W'(RD_BITS)) && rx_shift[RD_BITS-1]) begin
            re_d   = 1'b1;
            rd_d   = 1'b1;
            addr_d = rx_shift[ADDR_WIDTH-1:0];
          end
          if ((cnt_inc == CNT_W'(FRAME_W)) && !rx_shift[FRAME_W-1]) begin
            we_d    = 1'b1;
            addr_d  = rx_shift[DATA_WIDTH +: ADDR_WIDTH];
            wdata_d = rx_shift[DATA_WIDTH-1:0];
          end
        end else if (sck_fall && rd_q) begin
          sdo_d = tx_q[DATA_WIDTH-1];
          tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
    // Read data arrives one cycle after the read strobe
    if (load_q) tx_d = bus.reg_rdata;
    if (state_d == IDLE) sdo_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q     <= '0;
      bitcnt_q <= '0;
      tx_q     <= '0;
      rd_q     <= 1'b0;
      load_q   <= 1'b0;
      sdo_q    <= 1'b0;
      sdo_oe_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      rx_q     <= rx_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      sdo_q    <= sdo_d;
      sdo_oe_q <= sdo_oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      abort_q  <= abort_d;
    end
  end

  assign bus.sdo         = sdo_q;
  assign bus.sdo_oe      = sdo_oe_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_re      = re_q;
  assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: SPI master tasks, a register-map model
// and a strobe monitor, all checked against hand-computed values.
module tb_spi_slave_frontend;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LAT         = SYNC_STAGES + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_frontend_if bus_if ();

  spi_slave_frontend #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (8),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int we_cnt = 0, re_cnt = 0, abort_cnt = 0;
  int exp_we = 0, exp_re = 0;
  logic [6:0] last_we_addr, last_re_addr;
  logic [7:0] last_we_data;
  logic we_prev = 1'b0, re_prev = 1'b0;
  logic [7:0] mem [0:127];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register-map model: read data valid the cycle after reg_re
  always @(posedge clk) begin
    if (bus_if.reg_we) mem[bus_if.reg_addr] <= bus_if.reg_wdata;
    bus_if.reg_rdata <= bus_if.reg_re ? mem[bus_if.reg_addr] : 8'h00;
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.reg_we || bus_if.reg_re) begin
        check("we_re_excl", 32'(bus_if.reg_we & bus_if.reg_re), 32'd0);
        check("strobe_lat", 32'(cyc - last_rise_cyc), 32'(LAT));
      end
      if (bus_if.reg_we) begin
        check("we_width", 32'(we_prev), 32'd0);
        we_cnt++;
        last_we_addr = bus_if.reg_addr;
        last_we_data = bus_if.reg_wdata;
      end
      if (bus_if.reg_re) begin
        check("re_width", 32'(re_prev), 32'd0);
        re_cnt++;
        last_re_addr = bus_if.reg_addr;
      end
      if (bus_if.frame_abort) abort_cnt++;
    end
    we_prev = bus_if.reg_we;
    re_prev = bus_if.reg_re;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
    miso = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      bus_if.sdi = (i < 16) ? mosi[15-i] : 1'b0;
      wait_clk(5);
      if (i < 16) miso[15-i] = bus_if.sdo;
      bus_if.sck = 1'b1;
      last_rise_cyc = cyc;
      wait_clk(5);
      bus_if.sck = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
    bus_if.cs_n = 1'b0;
    wait_clk(5);
    shift_bits(mosi, nbits, miso);
    wait_clk(5);
    bus_if.cs_n = 1'b1;
    bus_if.sdi  = 1'b0;
    wait_clk(10);
  endtask

  logic [15:0] miso;
  logic [6:0]  addrs [8];
  logic [7:0]  datas [8];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'h3C;
    bus_if.sck  = 1'b0;
    bus_if.cs_n = 1'b1;
    bus_if.sdi  = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    check("reset_outs", 32'({bus_if.sdo, bus_if.sdo_oe, bus_if.reg_we, bus_if.reg_re,
                             bus_if.frame_abort, bus_if.reg_addr, bus_if.reg_wdata}), 32'd0);
    wait_clk(6);

    // Write 0x05 = 0xA5
    spi_xfer(16'h05A5, 16, miso); exp_we++;
    check("wr1_we_cnt", 32'(we_cnt), 32'(exp_we));
    check("wr1_addr", 32'(last_we_addr), 32'h05);
    check("wr1_data", 32'(last_we_data), 32'hA5);
    check("wr1_re_cnt", 32'(re_cnt), 32'd0);
    check("wr1_sdo", 32'(miso), 32'd0);

    // Read 0x10, model holds 0x3C
    spi_xfer(16'h9000, 16, miso); exp_re++;
    check("rd1_re_cnt", 32'(re_cnt), 32'(exp_re));
    check("rd1_addr", 32'(last_re_addr), 32'h10);
    check("rd1_hi", 32'(miso[15:8]), 32'h00);
    check("rd1_lo", 32'(miso[7:0]), 32'h3C);
    check("rd1_we_cnt", 32'(we_cnt), 32'(exp_we));

    // Abort after 10 rises of a write to 0x20
    spi_xfer(16'h2077, 10, miso);
    check("abort_cnt", 32'(abort_cnt), 32'd1);
    check("abort_no_we", 32'(we_cnt), 32'(exp_we));
    spi_xfer(16'h2011, 16, miso); exp_we++;
    check("post_abort_we", 32'(we_cnt), 32'(exp_we));
    check("post_abort_addr", 32'(last_we_addr), 32'h20);
    check("post_abort_data", 32'(last_we_data), 32'h11);

    // 20 rising edges: only the first 16 bits count
    spi_xfer(16'h3C5A, 20, miso); exp_we++;
    check("extra_we_cnt", 32'(we_cnt), 32'(exp_we));
    check("extra_addr", 32'(last_we_addr), 32'h3C);
    check("extra_data", 32'(last_we_data), 32'h5A);

    // Reset in the middle of a write with CS_N held low
    bus_if.cs_n = 1'b0;
    wait_clk(5);
    shift_bits(16'h0133, 12, miso);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("midrst_outs", 32'({bus_if.sdo, bus_if.sdo_oe, bus_if.reg_we, bus_if.reg_re,
                              bus_if.frame_abort, bus_if.reg_addr, bus_if.reg_wdata}), 32'd0);
    shift_bits(16'hFFFF, 4, miso);
    check("midrst_idle_oe", 32'(bus_if.sdo_oe), 32'd0);
    check("midrst_no_we", 32'(we_cnt), 32'(exp_we));
    bus_if.cs_n = 1'b1;
    wait_clk(10);
    spi_xfer(16'h01FF, 16, miso); exp_we++;
    check("postrst_we", 32'(we_cnt), 32'(exp_we));
    check("postrst_addr", 32'(last_we_addr), 32'h01);
    check("postrst_data", 32'(last_we_data), 32'hFF);

    // Write/read pairs to distinct addresses in 0x00-0x5F
    for (int k = 0; k < 8; k++) begin
      addrs[k] = 7'(k * 12 + $urandom_range(0, 11));
      datas[k] = 8'($urandom_range(0, 255));
    end
    for (int k = 0; k < 8; k++) begin
      spi_xfer({1'b0, addrs[k], datas[k]}, 16, miso); exp_we++;
      check("pair_wr_addr", 32'(last_we_addr), 32'(addrs[k]));
      spi_xfer({1'b1, addrs[k], 8'h00}, 16, miso); exp_re++;
      check("pair_rd_data", 32'(miso[7:0]), 32'(datas[k]));
    end
    check("final_we_cnt", 32'(we_cnt), 32'(exp_we));
    check("final_re_cnt", 32'(re_cnt), 32'(exp_re));
    check("final_abort_cnt", 32'(abort_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
